// File: rtl/softmax_row_sched_pkg.sv
// Shared constants and lane helpers for the softmax row scheduler.
// No state and no handshake of its own.
package softmax_row_sched_pkg;
    localparam int N          = 8;
    localparam int DW         = 16;
    localparam int MAX_CHUNKS = 16;
    localparam int CW         = $clog2(MAX_CHUNKS + 1);
    localparam int AW         = $clog2(MAX_CHUNKS);
    localparam int BW         = N * DW;

    localparam logic signed [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REPLAY} state_e;

    function automatic logic signed [DW-1:0] lane_get(input logic [BW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    function automatic logic [BW-1:0] lane_set(input logic [BW-1:0] v, input int i,
                                               input logic [DW-1:0] x);
        logic [BW-1:0] r;
        r = v;
        r[i*DW +: DW] = x;
        return r;
    endfunction

    function automatic logic [BW-1:0] lane_bcast(input logic [DW-1:0] x);
        return {N{x}};
    endfunction

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Zero-length rows still carry one beat; oversize rows are cut to the buffer depth.
    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] l);
        if (l == '0) return CW'(1);
        if (l > CW'(MAX_CHUNKS)) return CW'(MAX_CHUNKS);
        return l;
    endfunction
endpackage

// File: rtl/softmax_row_sched_if.sv
// Row input stream, replay output stream and status for the softmax row scheduler.
// Both streams use valid/ready; the master drives beats in and accepts replayed beats.
interface softmax_row_sched_if;
    import softmax_row_sched_pkg::*;

    logic [CW-1:0] row_len;
    logic [N-1:0]  last_mask;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] vect_x_in;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] vect_x_out;
    logic [BW-1:0] vect_max_out;
    logic          out_last;
    logic          busy;

    modport master (
        output row_len, last_mask, in_valid, vect_x_in, out_ready,
        input  in_ready, out_valid, vect_x_out, vect_max_out, out_last, busy
    );

    modport slave (
        input  row_len, last_mask, in_valid, vect_x_in, out_ready,
        output in_ready, out_valid, vect_x_out, vect_max_out, out_last, busy
    );
endinterface

// File: rtl/softmax_row_buf.sv
// Row buffer: MAX_CHUNKS x N*DW register array, one write port, one registered read port.
// Read data appears the cycle after rd_en_i and holds until the next read.
module softmax_row_buf
    import softmax_row_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [BW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [BW-1:0] rd_dat_o
);
    logic [BW-1:0] mem_q [MAX_CHUNKS];
    logic [BW-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rd_dat_q <= '0;
        else if (rd_en_i) rd_dat_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/softmax_row_sched.sv
// Buffers a row of up to MAX_CHUNKS beats, reduces its max, replays beats paired with the max.
// 1 beat/cycle each way; first output 2 cycles after the last input; outputs hold under stall.
module softmax_row_sched
    import softmax_row_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    softmax_row_sched_if.slave bus
);
    state_e               state_q, state_d;
    logic [CW-1:0]        len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [N-1:0]         mask_q, mask_d;
    logic signed [DW-1:0] max_q, max_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [BW-1:0]        max_out_q, max_out_d;

    logic [CW-1:0]        eff_len;
    logic [N-1:0]         eff_mask;
    logic                 in_xfer, out_xfer, last_out_xfer, wr_last, rd_load;
    logic [BW-1:0]        wr_beat, rd_dat;
    logic signed [DW-1:0] beat_max;

    function automatic logic signed [DW-1:0] lane_tree_max(input logic [BW-1:0] v);
        logic signed [DW-1:0] t [N];
        for (int i = 0; i < N; i++) t[i] = lane_get(v, i);
        for (int w = N / 2; w > 0; w = w / 2)
            for (int i = 0; i < w; i++) t[i] = smax(t[2*i], t[2*i+1]);
        return t[0];
    endfunction

    // Before the first beat is latched, length and mask come straight from the ports.
    assign eff_len       = (state_q == S_IDLE) ? clamp_len(bus.row_len) : len_q;
    assign eff_mask      = (state_q == S_IDLE) ? bus.last_mask : mask_q;
    assign wr_last       = (wr_ptr_q == eff_len - CW'(1));
    assign in_xfer       = bus.in_valid && in_ready_q;
    assign out_xfer      = out_valid_q && bus.out_ready;
    assign last_out_xfer = out_xfer && out_last_q;
    assign rd_load       = (state_q == S_REPLAY) && (rd_ptr_q != len_q)
                           && (!out_valid_q || bus.out_ready);

    always_comb begin
        wr_beat = bus.vect_x_in;
        for (int i = 0; i < N; i++)
            if (wr_last && !eff_mask[i]) wr_beat = lane_set(wr_beat, i, MIN);
    end

    assign beat_max = lane_tree_max(wr_beat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (in_xfer) state_d = wr_last ? S_REPLAY : S_LOAD;
            S_LOAD:   if (in_xfer && wr_last) state_d = S_REPLAY;
            S_REPLAY: if (last_out_xfer) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d       = len_q;
        mask_d      = mask_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        max_out_d   = max_out_q;
        in_ready_d  = (state_d != S_REPLAY);
        if (state_q == S_IDLE && in_xfer) begin
            len_d  = eff_len;
            mask_d = eff_mask;
        end
        if (in_xfer) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
            max_d    = smax(max_q, beat_max);
        end
        if (rd_load) begin
            rd_ptr_d    = rd_ptr_q + CW'(1);
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q == len_q - CW'(1));
            max_out_d   = lane_bcast(max_q);
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (last_out_xfer) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            max_d    = MIN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            mask_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            max_q       <= MIN;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            max_out_q   <= '0;
        end else begin
            len_q       <= len_d;
            mask_q      <= mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            max_q       <= max_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            max_out_q   <= max_out_d;
        end
    end

    softmax_row_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (in_xfer),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_dat_i  (wr_beat),
        .rd_en_i   (rd_load),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_dat_o  (rd_dat)
    );

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.vect_x_out   = rd_dat;
    assign bus.vect_max_out = max_out_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_softmax_row_sched.sv
// Bench for softmax_row_sched: directed and random rows against a row-level reference model.
module tb_softmax_row_sched;
    import softmax_row_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic [BW-1:0] in_beats [MAX_CHUNKS];

    softmax_row_sched_if bus ();

    softmax_row_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill_rand(input int nbeats);
        for (int b = 0; b < nbeats; b++)
            for (int i = 0; i < N; i++) in_beats[b][i*DW +: DW] = DW'($urandom);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_row(input logic [CW-1:0] len_f, input logic [N-1:0] mask, input int mode);
        logic [BW-1:0] exp_q [$];
        logic [BW-1:0] beat;
        int  len, m, v, got, budget, guard, bub_in, bub_out, t_last, t_first, k;
        bit  seen, rdy, xfer;
        logic [DW-1:0] exp_max;

        len = (len_f == 0) ? 1 : ((int'(len_f) > MAX_CHUNKS) ? MAX_CHUNKS : int'(len_f));
        m   = -32768;
        for (int b = 0; b < len; b++) begin
            beat = in_beats[b];
            for (int i = 0; i < N; i++) begin
                if (b == len - 1 && !mask[i]) beat[i*DW +: DW] = 16'h8000;
                v = int'($signed(beat[i*DW +: DW]));
                if (v > m) m = v;
            end
            exp_q.push_back(beat);
        end
        exp_max = m[DW-1:0];

        bub_in = 0;
        t_last = 0;
        for (int b = 0; b < len; b++) begin
            bus.in_valid  = 1'b1;
            bus.vect_x_in = in_beats[b];
            if (b == 0) begin
                bus.row_len   = len_f;
                bus.last_mask = mask;
            end else begin
                bus.row_len   = CW'($urandom);
                bus.last_mask = N'($urandom);
            end
            guard = 0;
            while (!bus.in_ready && guard < 50) begin
                bub_in++;
                guard++;
                tick();
            end
            t_last = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        chk("in_bubbles", BW'(bub_in), BW'(0));

        got = 0; budget = 0; bub_out = 0; seen = 0; t_first = -1; k = 0;
        while (got < len && budget < 300) begin
            if (bus.out_valid) begin
                if (!seen) begin
                    seen    = 1;
                    t_first = cyc;
                end
                chk("x_out",    bus.vect_x_out,   exp_q[got]);
                chk("max_out",  bus.vect_max_out, {N{exp_max}});
                chk("out_last", BW'(bus.out_last), BW'(got == len - 1));
            end else if (seen) begin
                bub_out++;
            end
            chk("in_rdy_replay", BW'(bus.in_ready), BW'(0));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((k % 3) == 0);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            k++;
            bus.out_ready = rdy;
            xfer = bus.out_valid && rdy;
            tick();
            if (xfer) got++;
            budget++;
        end
        bus.out_ready = 1'b0;
        chk("xfer_count",      BW'(got),           BW'(len));
        chk("latency",         BW'(t_first - t_last), BW'(2));
        chk("out_bubbles",     BW'(bub_out),       BW'(0));
        chk("valid_after_row", BW'(bus.out_valid), BW'(0));
        chk("in_rdy_next_row", BW'(bus.in_ready),  BW'(1));
        chk("busy_after_row",  BW'(bus.busy),      BW'(0));
    endtask

    initial begin
        rst           = 1'b0;
        bus.row_len   = '0;
        bus.last_mask = '0;
        bus.in_valid  = 1'b0;
        bus.vect_x_in = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  BW'(bus.in_ready),  BW'(0));
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_out_last",  BW'(bus.out_last),  BW'(0));
        chk("rst_busy",      BW'(bus.busy),      BW'(0));
        chk("rst_x_out",     bus.vect_x_out,     '0);
        chk("rst_max_out",   bus.vect_max_out,   '0);
        rst = 1'b1;
        chk("in_rdy_at_release", BW'(bus.in_ready), BW'(0));
        tick();
        chk("in_rdy_after_release", BW'(bus.in_ready), BW'(1));

        for (int i = 0; i < N; i++) in_beats[0][i*DW +: DW] = DW'(i + 1);
        run_row(CW'(1), 8'hFF, 0);

        fill_rand(3);
        for (int i = 0; i < N; i++) begin
            in_beats[0][i*DW +: DW] = DW'(16'h0100 - 3 * i);
            in_beats[2][i*DW +: DW] = DW'(16'hFF00 - i);
        end
        in_beats[1][3*DW +: DW] = 16'h7FFF;
        run_row(CW'(3), 8'hFF, 0);

        for (int i = 0; i < N; i++) begin
            in_beats[0][i*DW +: DW] = 16'h0010;
            in_beats[1][i*DW +: DW] = (i >= 4) ? 16'h7000 : 16'h0010;
        end
        run_row(CW'(2), 8'h0F, 0);

        fill_rand(4);
        run_row(CW'(4), 8'hFF, 1);

        fill_rand(MAX_CHUNKS);
        run_row(CW'(MAX_CHUNKS), 8'hFF, 0);
        fill_rand(1);
        run_row(CW'(0), 8'hFF, 0);

        for (int i = 0; i < N; i++) begin
            in_beats[0][i*DW +: DW] = 16'h8000;
            in_beats[1][i*DW +: DW] = 16'h8000;
        end
        run_row(CW'(2), 8'hFF, 0);

        fill_rand(3);
        for (int i = 0; i < N; i++) in_beats[2][i*DW +: DW] = 16'h7FFE;
        run_row(CW'(3), 8'h00, 1);

        for (int r = 0; r < 5; r++) begin
            fill_rand(MAX_CHUNKS);
            run_row(CW'($urandom_range(0, 20)), N'($urandom), 2);
        end

        // Abandon a len=5 row after one beat with an asynchronous reset.
        fill_rand(2);
        bus.row_len   = CW'(5);
        bus.last_mask = 8'hFF;
        bus.vect_x_in = in_beats[0];
        bus.in_valid  = 1'b1;
        tick();
        bus.vect_x_in = in_beats[1];
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready",  BW'(bus.in_ready),  BW'(0));
        chk("midrst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("midrst_out_last",  BW'(bus.out_last),  BW'(0));
        chk("midrst_busy",      BW'(bus.busy),      BW'(0));
        chk("midrst_x_out",     bus.vect_x_out,     '0);
        chk("midrst_max_out",   bus.vect_max_out,   '0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_rdy_after", BW'(bus.in_ready), BW'(1));
        fill_rand(2);
        for (int i = 0; i < N; i++) in_beats[1][i*DW +: DW] = DW'(16'hC000 + i);
        run_row(CW'(2), 8'hFF, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
